// File: rtl/vram_pkg.sv
// Shared definitions for the frame-buffer VRAM arbiter.
// Default widths, frame geometry and the arbiter op-state encoding.
package vram_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 12;
    localparam int FB_W       = 320;
    localparam int FB_H       = 240;

    // Operation driven onto the BRAM port during the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Write-post FIFO for the VRAM arbiter: DEPTH entries of {addr, data}.
// Storage is not reset; only pointers and occupancy are cleared.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] store_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         count_q, count_d;

    // Next pointer and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any queued words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push) store_q[wr_ptr_q] <= {push_addr, push_data};
    end

    assign {head_addr, head_data} = store_q[rd_ptr_q];
    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port frame-buffer BRAM between the display
// fetch path (absolute priority) and a FIFO-buffered writer that drains in
// cycles the display leaves free. Optional stall counter: VRAM_ARB_STALL_CNT_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_rvalid,
    output logic [DATA_W-1:0]             disp_rdata,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    input  logic                          stall_clr,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RV_W  = RD_LAT + 1;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    arb_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [RV_W-1:0]   rv_sr_q, rv_sr_d;
    logic              rdy_en_q;

    // wr_ready stays low through reset and rises on the first edge after release.
    assign wr_ready  = rdy_en_q && !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = !disp_req && !fifo_empty;

    vram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Op selection: display read first, else drain the FIFO head, else idle
    // with address/data held so the BRAM port does not toggle needlessly.
    always_comb begin
        state_d     = IDLE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (disp_req) begin
            state_d    = RD;
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr;
        end else if (!fifo_empty) begin
            state_d     = WR;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
        end
    end

    // Arbiter FSM with registered BRAM command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read-valid pipeline: one stage for the command register plus RD_LAT for the BRAM.
    always_comb begin
        rv_sr_d    = rv_sr_q;
        rv_sr_d[0] = disp_req;
        for (int i = 1; i < RV_W; i++) rv_sr_d[i] = rv_sr_q[i-1];
    end

    // Valid pipeline and post-reset ready enable; reset drops any in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_sr_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rv_sr_q  <= rv_sr_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = rv_sr_q[RD_LAT];
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
    assign busy        = (fifo_level != '0) || (state_q != IDLE) || (|rv_sr_q);

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Cycles where the writer has queued data but the display holds the port.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr)
            stall_cnt_d = '0;
        else if (!fifo_empty && disp_req && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Saturating stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural frame-buffer model.
module tb_vram_arbiter;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       disp_req = 1'b0;
    logic [ADDR_W-1:0]          disp_addr = '0;
    logic                       disp_rvalid;
    logic [DATA_W-1:0]          disp_rdata;
    logic                       wr_valid = 1'b0;
    logic                       wr_ready;
    logic [ADDR_W-1:0]          wr_addr = '0;
    logic [DATA_W-1:0]          wr_data = '0;
    logic                       mem_en, mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W-1:0]          mem_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                       busy;
    logic                       stall_clr = 1'b0;
`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0]                stall_cnt;
`endif

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fifo_level(fifo_level), .busy(busy)
`ifdef VRAM_ARB_STALL_CNT_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Frame-buffer BRAM: one-cycle registered read, indexed by the low address byte.
    logic [DATA_W-1:0] bram [256];
    logic [DATA_W-1:0] bram_rd = '0;
    logic              clr_mem = 1'b0;
    logic              pre_we = 1'b0;
    logic [7:0]        pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;
    assign mem_rdata = bram_rd;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) bram[i] <= '0;
        end else if (pre_we) begin
            bram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
            else        bram_rd <= bram[mem_addr[7:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } item_t;

    // Reference model state: what the frame buffer holds, what is queued, what is due.
    logic [DATA_W-1:0] refmem [256];
    item_t pending[$];
    item_t to_post[$];
    item_t rdq[$];
    item_t cmdq[$];
    item_t wrq[$];
    bit    model_ready = 0;
    int    last_sel = 0;
    bit    prev_rd = 0;
    int    stall_m = 0;
    bit    post_en = 1;

    int exp_level = 0;
    bit exp_ready = 0;
    bit exp_busy = 0;
    int exp_stall = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the expectations queued by stimulus.
    always @(negedge clk) begin
        bit exp_rv, exp_rd, exp_wr;
        chk("fifo_level", 32'(fifo_level), 32'(exp_level));
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
        if (rst) chk("reset_outputs", {mem_en, mem_we, disp_rvalid, 12'(disp_rdata)},
                     32'h0);
        if (rst) chk("reset_mem_bus", {3'b0, mem_addr, mem_wdata}, 32'h0);

        exp_rv = (rdq.size() != 0) && (rdq[0].due == cyc);
        chk("disp_rvalid", 32'(disp_rvalid), 32'(exp_rv));
        if (exp_rv) begin
            chk("disp_rdata", 32'(disp_rdata), 32'(rdq[0].data));
            void'(rdq.pop_front());
        end

        exp_rd = (cmdq.size() != 0) && (cmdq[0].due == cyc);
        chk("mem_read_cmd", 32'(mem_en && !mem_we), 32'(exp_rd));
        if (exp_rd) begin
            chk("mem_read_addr", 32'(mem_addr), 32'(cmdq[0].addr));
            void'(cmdq.pop_front());
        end

        exp_wr = (wrq.size() != 0) && (wrq[0].due == cyc);
        chk("mem_write_cmd", 32'(mem_en && mem_we), 32'(exp_wr));
        if (exp_wr) begin
            chk("mem_write_addr", 32'(mem_addr), 32'(wrq[0].addr));
            chk("mem_write_data", 32'(mem_wdata), 32'(wrq[0].data));
            void'(wrq.pop_front());
        end
    end

    // One clock of stimulus; the model decides this cycle's op from the arbiter rules.
    task automatic step(input bit dreq, input logic [ADDR_W-1:0] da, input bit clr);
        bit    wv;
        int    sel;
        item_t e;
        disp_req  = dreq;
        disp_addr = da;
        stall_clr = clr;
        wv = (to_post.size() != 0) && post_en;
        wr_valid = wv;
        if (wv) begin
            wr_addr = to_post[0].addr;
            wr_data = to_post[0].data;
        end else begin
            wr_addr = ADDR_W'($urandom);
            wr_data = DATA_W'($urandom);
        end

        exp_level = pending.size();
        exp_ready = model_ready && (pending.size() < FIFO_DEPTH);
        exp_busy  = (pending.size() != 0) || (last_sel != 0) || prev_rd;
        exp_stall = stall_m;
        if (clr) stall_m = 0;
        else if ((pending.size() != 0) && dreq && stall_m != 16'hFFFF) stall_m++;

        sel = 0;
        if (dreq) begin
            rdq.push_back('{cyc + 2, da, refmem[da[7:0]]});
            cmdq.push_back('{cyc + 1, da, '0});
            sel = 1;
        end else if (pending.size() != 0) begin
            e = pending.pop_front();
            refmem[e.addr[7:0]] = e.data;
            wrq.push_back('{cyc + 1, e.addr, e.data});
            sel = 2;
        end
        prev_rd  = (last_sel == 1);
        last_sel = sel;

        if (wv && exp_ready) pending.push_back(to_post.pop_front());
        model_ready = 1;

        @(posedge clk);
        #1;
    endtask

    task automatic post(input int a, input int d);
        to_post.push_back('{0, ADDR_W'(a), DATA_W'(d)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // Async reset mid-cycle; the model forgets queued and in-flight work.
    task automatic do_reset(input int n);
        rst = 1'b1;
        disp_req = 1'b0;
        wr_valid = 1'b0;
        stall_clr = 1'b0;
        rdq.delete(); cmdq.delete(); wrq.delete();
        pending.delete(); to_post.delete();
        last_sel = 0; prev_rd = 0; stall_m = 0; model_ready = 0;
        exp_level = 0; exp_ready = 0; exp_busy = 0; exp_stall = 0;
        for (int i = 0; i < 256; i++) refmem[i] = '0;
        clr_mem = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            clr_mem = 1'b0;
        end
        rst = 1'b0;
    endtask

    initial begin
        int n;
        do_reset(3);

        // Display read latency against a preloaded word.
        refmem[8'h10] = 12'hABC;
        pre_addr = 8'h10; pre_data = 12'hABC; pre_we = 1'b1;
        idle(1);
        pre_we = 1'b0;
        idle(3);
        step(1'b1, 17'h00010, 1'b0);
        idle(4);

        // Write drain in acceptance order.
        post(1, 12'h111); post(2, 12'h222); post(3, 12'h333);
        idle(10);

        // Display priority with the FIFO filling up, then blanking drain.
        for (int i = 0; i < 6; i++) post(8 + i, 12'h500 + i);
        for (int i = 0; i < 20; i++) step(1'b1, ADDR_W'(8 + (i % 6)), 1'b0);
        idle(12);

        // Simultaneous push and pop at level 2.
        post(20, 12'h0A1); post(21, 12'h0A2);
        for (int i = 0; i < 3; i++) step(1'b1, 17'd20, 1'b0);
        post(22, 12'h0A3);
        idle(6);

        // Stall counting with FIFO held non-empty, then a clear.
        post(30, 12'hC01);
        step(1'b1, 17'd30, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 17'd30, 1'b0);
        step(1'b1, 17'd30, 1'b1);
        idle(4);

        // Reset one cycle after a display request with three words queued.
        post(40, 12'hD01); post(41, 12'hD02); post(42, 12'hD03);
        for (int i = 0; i < 4; i++) step(1'b1, 17'd41, 1'b0);
        do_reset(2);
        idle(6);

        // Randomised traffic with line/blanking-shaped display requests.
        for (int i = 0; i < 1500; i++) begin
            bit dr;
            if (i == 700) do_reset(2);
            if (to_post.size() < 3 && ($urandom % 2) == 0)
                post($urandom % 32, $urandom % 4096);
            post_en = ($urandom % 4) != 0;
            dr = ((i % 40) < 26) ? (($urandom % 8) != 0) : (($urandom % 10) == 0);
            step(dr, ADDR_W'($urandom % 32), ($urandom % 64) == 0);
        end

        post_en = 1;
        n = 0;
        while ((to_post.size() != 0 || pending.size() != 0) && n < 200) begin
            idle(1);
            n++;
        end
        idle(4);
        chk("scoreboard_drained", 32'(rdq.size() + cmdq.size() + wrq.size()
                                     + pending.size() + to_post.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
